fetch_unit: RTL

//   PC register and instruction-fetch sequencer of the sequential RV64 core.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   PC register and instruction-fetch sequencer of the sequential RV64 core.
//   Holds the architectural PC, reads the 32-bit instruction at that PC from
//   instruction memory, presents it to decode over a valid/ready handshake and
//   then waits for the resolved next PC before fetching again. Also counts
//   retired instructions.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   imem_req/addr   single-cycle read request and address (addr=0 when idle)
//   imem_rvalid     read data valid, imem_rdata carries the instruction word
//   if_valid        instruction slot available to decode
//   if_ready        decode accepts the slot this cycle
//   if_pc/instr     PC and instruction word of the presented slot
//   if_fault        presented slot is a misaligned-fetch fault
//   pc_out          current PC (feeds the next-PC logic)
//   next_pc/_valid  resolved next PC from the next-PC logic
//   instret         retired-instruction counter (wraps modulo 2^64)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [63:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [63:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_fault,
  output logic [63:0]        pc_out,
  input  logic [63:0]        next_pc,
  input  logic               next_pc_valid,
  output logic [63:0]        instret
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_EXEC = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               fault_q, fault_d;
  logic [63:0]        instret_q, instret_d;

  // RV64I without the C extension needs 4-byte aligned fetch addresses.
  function automatic logic pc_aligned(input logic [63:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      fault_q   <= 1'b0;
      instret_q <= 64'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end

  // Next-state, datapath updates and state-decoded handshake outputs.
  // imem_req/if_valid are decoded purely from registered state, so they are
  // glitch-free and do not depend combinationally on any input.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    imem_addr = 64'h0;
    if_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (pc_aligned(pc_q)) begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          state_d   = ST_WAIT;
        end else begin
          // Misaligned target: no memory access, present a fault slot.
          fault_d = 1'b1;
          instr_d = '0;
          state_d = ST_HOLD;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          fault_d = 1'b0;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if_valid = 1'b1;
        // next_pc_valid is deliberately ignored here, even if it coincides
        // with if_ready; it must be presented again once in EXEC.
        if (if_ready) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_EXEC: begin
        if (next_pc_valid) begin
          // next_pc is loaded verbatim; misalignment is detected in REQ.
          pc_d      = next_pc;
          instret_d = instret_q + 64'd1;
          fault_d   = 1'b0;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_EXEC;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc_out   = pc_q;
  assign if_pc    = pc_q;
  assign if_instr = instr_q;
  assign if_fault = fault_q;
  assign instret  = instret_q;

endmodule
